round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Match/round sequencer for the fight game.
- Owns the health datapath's reset, gates combat via combat_en, runs the per-round clock and tallies round wins into a best-of-N match result.
- Sits between the top-level game FSM (start) and the health/attack logic (health_1/health_2 in; health_reset and combat_en out).
- Frame-rate driven via a single-cycle frame_tick strobe.

Parameters:
- HEALTH_W, 9, width of the health inputs.
- FULL_HEALTH, 200, value restored by health_reset; used only for timeout tie checks in tests.
- TICKS_PER_SEC, 60, frame_tick pulses per game second.
- ROUND_SECONDS, 99, round clock start value.
- INTRO_SECONDS, 3, pre-fight countdown length.
- KO_SECONDS, 2, post-round hold length.
- WINS_TO_MATCH, 2, round wins needed to take the match.
- MAX_ROUNDS, 5, hard round cap; covers repeated draws.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, level; begins a match from IDLE; ignored elsewhere.
- frame_tick, in, 1, one-cycle strobe per video frame.
- health_1, in, HEALTH_W, player 1 health.
- health_2, in, HEALTH_W, player 2 health.
- health_reset, out, 1, one-cycle pulse that restores both healths.
- combat_en, out, 1, high only in FIGHT; damage logic must AND it in.
- phase, out, 3, current state code.
- round_num, out, 3, 1-based current round.
- wins_1, out, 2, player 1 round wins.
- wins_2, out, 2, player 2 round wins.
- round_timer, out, 7, seconds left in round.
- intro_count, out, 2, countdown digit shown during INTRO.
- round_winner, out, 2, 00 none, 01 P1, 10 P2, 11 draw.
- match_winner, out, 2, same encoding; valid in MATCH_OVER.

Behaviour:
- Reset values: phase=IDLE, health_reset=0, combat_en=0, round_num=0, wins_1=wins_2=0, round_timer=ROUND_SECONDS, intro_count=0, round_winner=00, match_winner=00, sub-second counter=0.
- Reset has priority over every other event, including mid-round: the state is abandoned immediately and no health_reset pulse is issued.
- Second strobe: the sub-counter increments on frame_tick and wraps at TICKS_PER_SEC-1. The wrap cycle produces sec_pulse. The sub-counter clears on every state entry.
- IDLE -> INTRO when start=1:
  - round_num<=1, wins cleared, match_winner<=00.
- INTRO entry (from IDLE or KO):
  - health_reset=1 for exactly the entry cycle.
  - intro_count<=INTRO_SECONDS, round_timer<=ROUND_SECONDS, round_winner<=00.
  - Each sec_pulse decrements intro_count.
  - On the sec_pulse where intro_count==1, go to FIGHT; intro_count reads 0 in FIGHT.
- FIGHT: combat_en=1, registered, so it is high from the first FIGHT cycle. Checks in priority order, each cycle:
  - 1. health_1==0 and health_2==0 -> draw.
  - 2. health_2==0 -> P1 wins.
  - 3. health_1==0 -> P2 wins.
  - 4. On sec_pulse with round_timer==1: round_timer<=0 and timeout. Winner is the higher health; equal health is a draw.
  - Otherwise, on sec_pulse, round_timer decrements.
  - A KO beats a timeout in the same cycle.
- Any round end -> KO:
  - combat_en<=0 in the same edge.
  - round_winner latched.
  - Winner's wins counter increments; a draw increments neither.
- KO holds for KO_SECONDS sec_pulses, then:
  - If either wins count >= WINS_TO_MATCH, or round_num==MAX_ROUNDS, go to MATCH_OVER. match_winner is the player with more wins; equal wins is 11.
  - Otherwise round_num increments and the state goes to INTRO.
- MATCH_OVER: all outputs hold. start=1 -> INTRO with round_num=1 and wins cleared, as from IDLE.
- Health changes outside FIGHT are ignored.
- Counters never wrap below 0 or above their limits.

Optional Feature:
- Macro: ROUND_PAUSE_EN.
- When defined, adds input pause (1 bit, level). While pause=1 in INTRO, FIGHT or KO:
  - sub-counter, round_timer and intro_count freeze;
  - combat_en is forced 0;
  - KO/timeout checks are suspended;
  - phase is unchanged.
- On release, sequencing resumes from the frozen values.
- pause is ignored in IDLE and MATCH_OVER.
- Without the macro: no pause port, and the logic is absent.

Decomposition:
- Package round_pkg holds:
  - phase codes: IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_OVER=4;
  - winner codes: NONE=00, P1=01, P2=10, DRAW=11.
- One natural sub-module: sec_timer, the frame_tick divider producing sec_pulse with a synchronous clear input. The FSM, tallies and down-counters stay in round_controller.

Test Plan:
All scenarios use TICKS_PER_SEC=2, INTRO_SECONDS=3, ROUND_SECONDS=5, KO_SECONDS=2, with frame_tick every cycle.
- start=1 from IDLE -> health_reset pulses 1 cycle; intro_count reads 3,2,1; FIGHT entered after 6 ticks with combat_en=1 and round_timer=5.
- health_2 forced 0 mid-FIGHT -> next edge KO, round_winner=01, wins_1=1; after 4 ticks INTRO, round_num=2, health_reset pulses again.
- Health held 150/120 until timeout -> round_timer reaches 0, round_winner=01. Repeat with 150/150 -> round_winner=11, wins unchanged.
- Both healths reach 0 in the same cycle that round_timer hits 0 -> draw recorded as KO; round_timer=0; no win increment.
- P2 wins two rounds -> MATCH_OVER, match_winner=10, combat_en=0. Then start=1 -> round_num=1, wins 0/0.
- reset asserted mid-FIGHT with round_timer=3 -> next cycle IDLE with all reset values and no health_reset pulse. With ROUND_PAUSE_EN, pause for 10 cycles in FIGHT -> round_timer unchanged and combat_en=0.

Source files
------------

// File: rtl/round_pkg.sv
// Shared encodings and helpers for the round/match sequencer.
package round_pkg;

  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned ROUND_W  = 3;
  localparam int unsigned WINS_W   = 2;
  localparam int unsigned TIMER_W  = 7;
  localparam int unsigned INTRO_W  = 2;
  localparam int unsigned WINNER_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE       = 3'd0,
    PH_INTRO      = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_KO         = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_e;

  typedef enum logic [WINNER_W-1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Larger score wins; equal scores are a draw.
  function automatic winner_e pick_winner(input int unsigned a, input int unsigned b);
    if (a > b)      return WIN_P1;
    else if (b > a) return WIN_P2;
    else            return WIN_DRAW;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Frame-tick divider: one sec_pulse_c per TICKS_PER_SEC frame ticks, with synchronous clear.
module sec_timer #(
  parameter int unsigned TICKS_PER_SEC = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic sec_pulse_c
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TICKS_PER_SEC > 0) ? TICKS_PER_SEC - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pulse on the tick that wraps the counter; clear does not mask it (clear is driven by the pulse).
  assign sec_pulse_c = tick & (cnt_q == LAST);

  // Next count: clear wins, otherwise count ticks and wrap at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Sub-second counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_controller.sv
// Match/round sequencer: intro countdown, fight clock, KO hold and best-of-N tally.
// Optional build macro ROUND_PAUSE_EN adds a level 'pause' input that freezes INTRO/FIGHT/KO.
module round_controller
  import round_pkg::*;
#(
  parameter int unsigned HEALTH_W      = 9,
  parameter int unsigned FULL_HEALTH   = 200,
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS = 99,
  parameter int unsigned INTRO_SECONDS = 3,
  parameter int unsigned KO_SECONDS    = 2,
  parameter int unsigned WINS_TO_MATCH = 2,
  parameter int unsigned MAX_ROUNDS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                frame_tick,
`ifdef ROUND_PAUSE_EN
  input  logic                pause,
`endif
  input  logic [HEALTH_W-1:0] health_1,
  input  logic [HEALTH_W-1:0] health_2,
  output logic                health_reset,
  output logic                combat_en,
  output logic [PHASE_W-1:0]  phase,
  output logic [ROUND_W-1:0]  round_num,
  output logic [WINS_W-1:0]   wins_1,
  output logic [WINS_W-1:0]   wins_2,
  output logic [TIMER_W-1:0]  round_timer,
  output logic [INTRO_W-1:0]  intro_count,
  output logic [WINNER_W-1:0] round_winner,
  output logic [WINNER_W-1:0] match_winner
);

  localparam int unsigned KO_W = (KO_SECONDS > 1) ? $clog2(KO_SECONDS) : 1;
  localparam logic [KO_W-1:0] KO_LAST = KO_W'((KO_SECONDS > 0) ? KO_SECONDS - 1 : 0);

  // Restored health must be representable on the health bus.
  if (FULL_HEALTH >= (32'd1 << HEALTH_W)) begin : g_full_health_check
    $error("FULL_HEALTH does not fit in HEALTH_W bits");
  end

  phase_e              state_q, state_d;
  logic [ROUND_W-1:0]  round_num_q, round_num_d;
  logic [WINS_W-1:0]   wins_1_q, wins_1_d;
  logic [WINS_W-1:0]   wins_2_q, wins_2_d;
  logic [TIMER_W-1:0]  round_timer_q, round_timer_d;
  logic [INTRO_W-1:0]  intro_count_q, intro_count_d;
  logic [KO_W-1:0]     ko_cnt_q, ko_cnt_d;
  winner_e             round_winner_q, round_winner_d;
  winner_e             match_winner_q, match_winner_d;
  logic                health_reset_q, health_reset_d;
  logic                combat_en_q, combat_en_d;

  logic                paused;
  logic                sec_pulse;
  logic                sub_clr;
  logic                enter_intro;
  logic                end_round;
  winner_e             end_w;

  // Pause only acts while a round is in progress.
`ifdef ROUND_PAUSE_EN
  assign paused = pause & ((state_q == PH_INTRO) | (state_q == PH_FIGHT) | (state_q == PH_KO));
`else
  assign paused = 1'b0;
`endif

  // Sub-second counter restarts on every state change.
  assign sub_clr = (state_d != state_q);

  sec_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_timer (
    .clk         (clk),
    .reset       (reset),
    .clr         (sub_clr),
    .tick        (frame_tick & ~paused),
    .sec_pulse_c (sec_pulse)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    round_num_d    = round_num_q;
    wins_1_d       = wins_1_q;
    wins_2_d       = wins_2_q;
    round_timer_d  = round_timer_q;
    intro_count_d  = intro_count_q;
    ko_cnt_d       = ko_cnt_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    health_reset_d = 1'b0;
    enter_intro    = 1'b0;
    end_round      = 1'b0;
    end_w          = WIN_NONE;

    case (state_q)
      PH_IDLE, PH_MATCH_OVER: begin
        if (start) begin
          enter_intro    = 1'b1;
          round_num_d    = ROUND_W'(1);
          wins_1_d       = '0;
          wins_2_d       = '0;
          match_winner_d = WIN_NONE;
        end
      end

      PH_INTRO: begin
        if (!paused && sec_pulse) begin
          if (intro_count_q <= INTRO_W'(1)) begin
            state_d       = PH_FIGHT;
            intro_count_d = '0;
          end else begin
            intro_count_d = intro_count_q - INTRO_W'(1);
          end
        end
      end

      PH_FIGHT: begin
        if (!paused) begin
          if (sec_pulse && (round_timer_q != '0)) begin
            round_timer_d = round_timer_q - TIMER_W'(1);
          end
          if ((health_1 == '0) && (health_2 == '0)) begin
            end_round = 1'b1;
            end_w     = WIN_DRAW;
          end else if (health_2 == '0) begin
            end_round = 1'b1;
            end_w     = WIN_P1;
          end else if (health_1 == '0) begin
            end_round = 1'b1;
            end_w     = WIN_P2;
          end else if (sec_pulse && (round_timer_q <= TIMER_W'(1))) begin
            end_round = 1'b1;
            end_w     = pick_winner(32'(health_1), 32'(health_2));
          end
        end
        if (end_round) begin
          state_d        = PH_KO;
          ko_cnt_d       = '0;
          round_winner_d = end_w;
          if ((end_w == WIN_P1) && (wins_1_q != '1)) wins_1_d = wins_1_q + WINS_W'(1);
          if ((end_w == WIN_P2) && (wins_2_q != '1)) wins_2_d = wins_2_q + WINS_W'(1);
        end
      end

      PH_KO: begin
        if (!paused && sec_pulse) begin
          if (ko_cnt_q >= KO_LAST) begin
            if ((32'(wins_1_q) >= WINS_TO_MATCH) || (32'(wins_2_q) >= WINS_TO_MATCH) ||
                (32'(round_num_q) >= MAX_ROUNDS)) begin
              state_d        = PH_MATCH_OVER;
              match_winner_d = pick_winner(32'(wins_1_q), 32'(wins_2_q));
            end else begin
              enter_intro = 1'b1;
              if (round_num_q != '1) round_num_d = round_num_q + ROUND_W'(1);
            end
          end else begin
            ko_cnt_d = ko_cnt_q + KO_W'(1);
          end
        end
      end

      default: begin
        state_d = PH_IDLE;
      end
    endcase

    // Common round-start actions, shared by every path into INTRO.
    if (enter_intro) begin
      state_d        = PH_INTRO;
      health_reset_d = 1'b1;
      intro_count_d  = INTRO_W'(INTRO_SECONDS);
      round_timer_d  = TIMER_W'(ROUND_SECONDS);
      round_winner_d = WIN_NONE;
    end

    combat_en_d = (state_d == PH_FIGHT) & ~paused;
  end

  // State and output registers; reset abandons any round without a health_reset pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PH_IDLE;
      round_num_q    <= '0;
      wins_1_q       <= '0;
      wins_2_q       <= '0;
      round_timer_q  <= TIMER_W'(ROUND_SECONDS);
      intro_count_q  <= '0;
      ko_cnt_q       <= '0;
      round_winner_q <= WIN_NONE;
      match_winner_q <= WIN_NONE;
      health_reset_q <= 1'b0;
      combat_en_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_num_q    <= round_num_d;
      wins_1_q       <= wins_1_d;
      wins_2_q       <= wins_2_d;
      round_timer_q  <= round_timer_d;
      intro_count_q  <= intro_count_d;
      ko_cnt_q       <= ko_cnt_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      health_reset_q <= health_reset_d;
      combat_en_q    <= combat_en_d;
    end
  end

  assign phase        = state_q;
  assign round_num    = round_num_q;
  assign wins_1       = wins_1_q;
  assign wins_2       = wins_2_q;
  assign round_timer  = round_timer_q;
  assign intro_count  = intro_count_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;
  assign health_reset = health_reset_q;
  assign combat_en    = combat_en_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller (small timing: 2 ticks/s, 3 s intro, 5 s round, 2 s KO).
module tb_round_controller;

  localparam int P_IDLE  = 0;
  localparam int P_INTRO = 1;
  localparam int P_FIGHT = 2;
  localparam int P_KO    = 3;
  localparam int P_OVER  = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       frame_tick;
`ifdef ROUND_PAUSE_EN
  logic       pause;
`endif
  logic [8:0] health_1;
  logic [8:0] health_2;
  logic       health_reset;
  logic       combat_en;
  logic [2:0] phase;
  logic [2:0] round_num;
  logic [1:0] wins_1;
  logic [1:0] wins_2;
  logic [6:0] round_timer;
  logic [1:0] intro_count;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  int n_checks;
  int n_fail;

  typedef struct {
    int h1; int h2;        // health held through the round
    int kill_k;            // FIGHT cycle at which kill values are applied (-1 = never)
    int k1; int k2;        // kill health values
    int exp_w;             // expected round winner code
    int exp_t;             // expected round_timer in KO
    int exp_over;          // 1 if this round ends the match
    int exp_mw;            // expected match winner when exp_over
  } rvec_t;

  typedef struct { int w; int w1; int w2; int t; } sb_t;

  rvec_t tbl[11];
  sb_t   sbq[$];
  int    m_w1, m_w2, m_round;

  round_controller #(
    .HEALTH_W      (9),
    .FULL_HEALTH   (200),
    .TICKS_PER_SEC (2),
    .ROUND_SECONDS (5),
    .INTRO_SECONDS (3),
    .KO_SECONDS    (2),
    .WINS_TO_MATCH (2),
    .MAX_ROUNDS    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_tick   (frame_tick),
`ifdef ROUND_PAUSE_EN
    .pause        (pause),
`endif
    .health_1     (health_1),
    .health_2     (health_2),
    .health_reset (health_reset),
    .combat_en    (combat_en),
    .phase        (phase),
    .round_num    (round_num),
    .wins_1       (wins_1),
    .wins_2       (wins_2),
    .round_timer  (round_timer),
    .intro_count  (intro_count),
    .round_winner (round_winner),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (int'(phase) != target && n < budget) begin
      step();
      n++;
    end
    check(name, int'(phase), target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"},        int'(phase), P_IDLE);
    check({tag, "_health_reset"}, int'(health_reset), 0);
    check({tag, "_combat_en"},    int'(combat_en), 0);
    check({tag, "_round_num"},    int'(round_num), 0);
    check({tag, "_wins_1"},       int'(wins_1), 0);
    check({tag, "_wins_2"},       int'(wins_2), 0);
    check({tag, "_round_timer"},  int'(round_timer), 5);
    check({tag, "_intro_count"},  int'(intro_count), 0);
    check({tag, "_round_winner"}, int'(round_winner), 0);
    check({tag, "_match_winner"}, int'(match_winner), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b1;
    health_1 = 9'd200; health_2 = 9'd200;
`ifdef ROUND_PAUSE_EN
    pause = 1'b0;
`endif

    // Round table: h1, h2, kill_k, k1, k2, winner, timer, over, match winner
    tbl[0]  = '{200, 200,  3, 200,   0, 1, 3, 0, 0};  // P2 KO'd mid round
    tbl[1]  = '{150, 150, -1,   0,   0, 3, 0, 0, 0};  // timeout, equal health
    tbl[2]  = '{150, 120, -1,   0,   0, 1, 0, 1, 1};  // timeout, P1 ahead -> match P1
    tbl[3]  = '{200, 200,  9,   0,   0, 3, 0, 0, 0};  // double KO on the timeout second
    tbl[4]  = '{200, 200,  0,   0, 200, 2, 5, 0, 0};  // P1 KO'd on first FIGHT cycle
    tbl[5]  = '{180,  90,  5,   0,  90, 2, 2, 1, 2};  // P2 second win -> match P2
    tbl[6]  = '{200, 200,  2,   0,   0, 3, 4, 0, 0};  // five draws -> round cap
    tbl[7]  = '{200, 200,  2,   0,   0, 3, 4, 0, 0};
    tbl[8]  = '{200, 200,  2,   0,   0, 3, 4, 0, 0};
    tbl[9]  = '{200, 200,  2,   0,   0, 3, 4, 0, 0};
    tbl[10] = '{200, 200,  2,   0,   0, 3, 4, 1, 3};

    // Reset state
    step(); step();
    check_reset_values("rst");
    reset = 1'b0;
    step();
    check("idle_hold_phase", int'(phase), P_IDLE);

    // Start: one-cycle health_reset, intro 3,3,2,2,1,1 then FIGHT
    start = 1'b1;
    step();
    start = 1'b0;
    check("intro_health_reset", int'(health_reset), 1);
    check("intro_round_num", int'(round_num), 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("intro_count_c%0d", i), int'(intro_count), 3 - i / 2);
      check($sformatf("intro_phase_c%0d", i), int'(phase), P_INTRO);
      if (i == 1) check("intro_health_reset_off", int'(health_reset), 0);
      step();
    end
    check("fight_phase", int'(phase), P_FIGHT);
    check("fight_combat_en", int'(combat_en), 1);
    check("fight_round_timer", int'(round_timer), 5);
    check("fight_intro_count", int'(intro_count), 0);

    // Table-driven rounds with a scoreboard of KO results
    m_w1 = 0; m_w2 = 0; m_round = 1;
    for (int i = 0; i < 11; i++) begin
      rvec_t v;
      sb_t   e;
      int    n;
      v = tbl[i];
      if (int'(phase) == P_OVER) begin
        start = 1'b1;
        step();
        start = 1'b0;
        m_w1 = 0; m_w2 = 0; m_round = 1;
        check($sformatf("r%0d_restart_phase", i), int'(phase), P_INTRO);
        check($sformatf("r%0d_restart_round", i), int'(round_num), 1);
        check($sformatf("r%0d_restart_wins_1", i), int'(wins_1), 0);
        check($sformatf("r%0d_restart_wins_2", i), int'(wins_2), 0);
        check($sformatf("r%0d_restart_hreset", i), int'(health_reset), 1);
      end
      health_1 = 9'(v.h1);
      health_2 = 9'(v.h2);
      wait_phase(P_FIGHT, 20, $sformatf("r%0d_reach_fight", i));

      if (v.exp_w == 1) m_w1++;
      else if (v.exp_w == 2) m_w2++;
      sbq.push_back('{v.exp_w, m_w1, m_w2, v.exp_t});

      n = 0;
      while (int'(phase) == P_FIGHT && n < 20) begin
        if (n == v.kill_k) begin
          health_1 = 9'(v.k1);
          health_2 = 9'(v.k2);
        end
        step();
        n++;
      end
      check($sformatf("r%0d_reach_ko", i), int'(phase), P_KO);
      check($sformatf("r%0d_sb_depth", i), sbq.size(), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("r%0d_round_winner", i), int'(round_winner), e.w);
        check($sformatf("r%0d_wins_1", i), int'(wins_1), e.w1);
        check($sformatf("r%0d_wins_2", i), int'(wins_2), e.w2);
        check($sformatf("r%0d_round_timer", i), int'(round_timer), e.t);
      end
      check($sformatf("r%0d_ko_combat_en", i), int'(combat_en), 0);

      n = 0;
      while (int'(phase) == P_KO && n < 10) begin
        step();
        n++;
      end
      check($sformatf("r%0d_ko_len", i), n, 4);
      if (v.exp_over != 0) begin
        check($sformatf("r%0d_over_phase", i), int'(phase), P_OVER);
        check($sformatf("r%0d_match_winner", i), int'(match_winner), v.exp_mw);
        check($sformatf("r%0d_over_combat_en", i), int'(combat_en), 0);
        step(); step();
        check($sformatf("r%0d_over_hold_phase", i), int'(phase), P_OVER);
        check($sformatf("r%0d_over_hold_mw", i), int'(match_winner), v.exp_mw);
      end else begin
        m_round++;
        check($sformatf("r%0d_next_phase", i), int'(phase), P_INTRO);
        check($sformatf("r%0d_next_round", i), int'(round_num), m_round);
        check($sformatf("r%0d_next_hreset", i), int'(health_reset), 1);
        check($sformatf("r%0d_next_rw_clear", i), int'(round_winner), 0);
      end
    end

    // Reset mid-FIGHT with round_timer == 3
    health_1 = 9'd200; health_2 = 9'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(P_FIGHT, 20, "rstmid_reach_fight");
    for (int n = 0; n < 20 && int'(round_timer) != 3; n++) step();
    check("rstmid_timer", int'(round_timer), 3);
    reset = 1'b1;
    step();
    check_reset_values("rstmid");
    reset = 1'b0;
    step();
    check("rstmid_after_phase", int'(phase), P_IDLE);
    check("rstmid_after_hreset", int'(health_reset), 0);

`ifdef ROUND_PAUSE_EN
    // Pause in FIGHT freezes the clock, masks combat and suspends the KO check
    start = 1'b1;
    step();
    start = 1'b0;
    wait_phase(P_FIGHT, 20, "pause_reach_fight");
    step(); step();
    pause = 1'b1;
    health_2 = 9'd0;
    for (int n = 0; n < 10; n++) step();
    check("pause_phase", int'(phase), P_FIGHT);
    check("pause_timer", int'(round_timer), 4);
    check("pause_combat_en", int'(combat_en), 0);
    pause = 1'b0;
    step();
    check("pause_release_phase", int'(phase), P_KO);
    check("pause_release_winner", int'(round_winner), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
